// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU ready generator: FSM encoding, timeout data
// default and a constant-safe clog2.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StRdy
    } rdy_state_e;

    localparam logic [63:0] TmoDataAllOnes = '1;

    // Never returns 0 so it can size a vector directly.
    function automatic int unsigned clog2(input int unsigned val);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(val)) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/cpu_rdygen_mc_if.sv
// CPU-side and slave-side access signals of the multi-channel ready generator.
interface cpu_rdygen_mc_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned SW  = 2,
    parameter int unsigned DW  = 16
);
    logic              pce_;
    logic [SW-1:0]     csel;
    logic [NCH-1:0]    rdyin;
    logic [NCH*DW-1:0] rdin;
    logic              rdyout;
    logic [DW-1:0]     rdout;

    modport master (
        output pce_, csel, rdyin, rdin,
        input  rdyout, rdout
    );

    modport slave (
        input  pce_, csel, rdyin, rdin,
        output rdyout, rdout
    );
endinterface

// File: rtl/rdy_wait_cnt.sv
// Access-cycle counter that saturates at TMO_CYC and flags the minimum-wait
// and timeout thresholds.
module rdy_wait_cnt #(
    parameter int unsigned CW       = 8,
    parameter int unsigned MIN_WAIT = 0,
    parameter int unsigned TMO_CYC  = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic min_ok,
    output logic tmo_hit
);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CW'(TMO_CYC))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmo_hit = (cnt_q == CW'(TMO_CYC));

    // A zero threshold is always met; avoids a constant unsigned compare.
    if (MIN_WAIT == 0) begin : g_nomin
        assign min_ok = 1'b1;
    end else begin : g_min
        assign min_ok = (cnt_q >= CW'(MIN_WAIT));
    end
endmodule

// File: rtl/cpu_rdygen_mc.sv
// Multi-channel CPU ready stretcher: selects one slave per access, enforces a
// minimum wait, holds ready/data sticky until pce_ rises, times out if silent.
module cpu_rdygen_mc
    import cpu_bus_pkg::*;
#(
    parameter int unsigned    NCH      = 4,
    parameter int unsigned    SW       = 2,
    parameter int unsigned    DW       = 16,
    parameter int unsigned    MIN_WAIT = 0,
    parameter int unsigned    TMO_CYC  = 255,
    parameter logic [DW-1:0]  TMO_DATA = TmoDataAllOnes[DW-1:0]
) (
    input  logic          clk,
    input  logic          rst,
    cpu_rdygen_mc_if.slave bus,
    output logic          tmo_err,
    output logic          tmo_flag,
    output logic [SW-1:0] tmo_ch,
    input  logic          tmo_clr
);
    localparam int unsigned CW = clog2(TMO_CYC + 1);

    rdy_state_e    state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          pend_q, pend_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          rdyout_q, rdyout_d;
    logic [DW-1:0] rdout_q, rdout_d;
    logic          tmo_err_q, tmo_err_d;
    logic          tmo_flag_q, tmo_flag_d;
    logic [SW-1:0] tmo_ch_q, tmo_ch_d;

    logic          cnt_clr, cnt_en, min_ok, tmo_hit;
    logic          sel_rdy;
    logic [DW-1:0] sel_data;

    rdy_wait_cnt #(
        .CW       (CW),
        .MIN_WAIT (MIN_WAIT),
        .TMO_CYC  (TMO_CYC)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .min_ok  (min_ok),
        .tmo_hit (tmo_hit)
    );

    // Selects beyond NCH match no channel and so never see ready.
    always_comb begin
        sel_rdy  = 1'b0;
        sel_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (SW'(i) == sel_q) begin
                sel_rdy  = bus.rdyin[i];
                sel_data = bus.rdin[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        pend_d     = pend_q;
        hold_d     = hold_q;
        rdyout_d   = rdyout_q;
        rdout_d    = rdout_q;
        tmo_err_d  = 1'b0;
        tmo_flag_d = tmo_flag_q & ~tmo_clr;
        tmo_ch_d   = tmo_ch_q;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;

        if (bus.pce_) begin
            state_d  = StIdle;
            rdyout_d = 1'b0;
            pend_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    sel_d   = bus.csel;
                    pend_d  = 1'b0;
                    cnt_clr = 1'b1;
                    state_d = StWait;
                end
                StWait: begin
                    cnt_en = 1'b1;
                    if (sel_rdy && !pend_q) begin
                        pend_d = 1'b1;
                        hold_d = sel_data;
                    end
                    // Ready wins over a coincident timeout.
                    if ((pend_q || sel_rdy) && min_ok) begin
                        state_d  = StRdy;
                        rdyout_d = 1'b1;
                        rdout_d  = pend_q ? hold_q : sel_data;
                    end else if (tmo_hit && !pend_q && !sel_rdy) begin
                        state_d    = StRdy;
                        rdyout_d   = 1'b1;
                        rdout_d    = TMO_DATA;
                        tmo_err_d  = 1'b1;
                        tmo_flag_d = 1'b1;
                        tmo_ch_d   = sel_q;
                    end
                end
                StRdy: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            pend_q     <= 1'b0;
            hold_q     <= '0;
            rdyout_q   <= 1'b0;
            rdout_q    <= '0;
            tmo_err_q  <= 1'b0;
            tmo_flag_q <= 1'b0;
            tmo_ch_q   <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            pend_q     <= pend_d;
            hold_q     <= hold_d;
            rdyout_q   <= rdyout_d;
            rdout_q    <= rdout_d;
            tmo_err_q  <= tmo_err_d;
            tmo_flag_q <= tmo_flag_d;
            tmo_ch_q   <= tmo_ch_d;
        end
    end

    assign bus.rdyout = rdyout_q;
    assign bus.rdout  = rdout_q;
    assign tmo_err    = tmo_err_q;
    assign tmo_flag   = tmo_flag_q;
    assign tmo_ch     = tmo_ch_q;
endmodule
